spike_packet_receiver: RTL
==========================

SPIKE_PACKET_RECEIVER -- requirements
Module: spike_packet_receiver

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 10, number of local neurons / MAC lanes.
REQ-002 SHALL have parameter ADDR_W, default 12, neuron address width.
REQ-003 SHALL have parameter BASE_ADDR, default 0, address of local lane 0.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, power of two, ingress buffer entries.
REQ-005 SHALL have port CLK, input, 1, sole clock, rising edge.
REQ-006 SHALL have port RESET_N, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port clear, input, 1, timestep boundary, active high.
REQ-008 SHALL have port pkt_in, input, 2*ADDR_W, {spiking neuron addr [23:12], destination neuron addr [11:0]}.
REQ-009 SHALL have port pkt_valid, input, 1, pkt_in valid.
REQ-010 SHALL have port pkt_ready, output, 1, receiver can accept.
REQ-011 SHALL have port src_addr_out, output, NUM_NEURONS*ADDR_W, per-lane source address; lane k at [k*ADDR_W +: ADDR_W].
REQ-012 SHALL have port src_valid, output, NUM_NEURONS, one-hot per-lane delivery strobe.
REQ-013 SHALL have port fifo_count, output, clog2(FIFO_DEPTH)+1, current occupancy.
REQ-014 SHALL have port drop_count, output, 16, non-local packets discarded.

Function
REQ-015 Transfer SHALL occur on a rising CLK edge with pkt_valid and pkt_ready both high.
REQ-016 pkt_ready SHALL equal (fifo_count != FIFO_DEPTH), registered-state only, no combinational path from pkt_valid.
REQ-017 A full FIFO SHALL not accept a push even when a pop occurs in the same cycle.
REQ-018 Destination d is local iff BASE_ADDR <= d < BASE_ADDR+NUM_NEURONS; lane = d-BASE_ADDR.
REQ-019 A non-local packet SHALL be accepted (pkt_ready rules unchanged), never enter the FIFO, and increment drop_count, saturating at 16'hFFFF.
REQ-020 The FSM SHALL have states IDLE (FIFO empty), DISPATCH (popping one entry per cycle), HOLD (clear high).
REQ-021 Transitions: IDLE->DISPATCH when FIFO non-empty and clear low; any->HOLD when clear high; HOLD->DISPATCH/IDLE when clear low, by occupancy; DISPATCH->IDLE when the last entry pops.
REQ-022 In DISPATCH, each cycle SHALL pop the head and, on the next edge, drive src_valid[lane]=1 and the lane's src_addr_out slice = spiking address for exactly one cycle.
REQ-023 Minimum latency: packet accepted at edge N SHALL produce src_valid at edge N+2 (visible during cycle N+2).
REQ-024 src_valid SHALL be all-zero in IDLE and HOLD; at most one bit high in any cycle.
REQ-025 src_addr_out slices SHALL hold their last delivered value when not strobed.
REQ-026 While clear is high, the FIFO SHALL keep accepting; no entry is lost or reordered.
REQ-027 Packets SHALL be delivered in arrival order; back-to-back packets to the same lane SHALL produce strobes in consecutive cycles.
REQ-028 Simultaneous push and pop on a non-full FIFO SHALL leave fifo_count unchanged.

Reset
REQ-029 RESET_N low SHALL asynchronously force: FSM=IDLE, FIFO empty, fifo_count=0, pkt_ready=1 after release, src_valid=0, src_addr_out=0, drop_count=0.
REQ-030 Reset mid-dispatch SHALL discard all buffered packets; no strobe after release until new packets are accepted.

Structure
REQ-031 Packet width, field offsets, and FSM state encodings SHALL live in a shared package, spike_pkg.
REQ-032 Ingress buffer SHALL be a separate sub-module spike_fifo (synchronous, single clock, async active-low reset).

Verification
REQ-033 Push 24'h003005 -> at +2 edges src_valid=10'b0000100000, lane 5 slice=12'h003, one cycle only.
REQ-034 Push destination 12'hFFB -> drop_count=1, no src_valid, fifo_count stays 0.
REQ-035 Hold clear high; push 9 local packets -> pkt_ready low after 8, fifo_count=8; drop clear -> 8 consecutive one-hot strobes in order.
REQ-036 Push {12'd1,12'd4},{12'd2,12'd4},{12'd7,12'd4} back-to-back -> lane 4 strobes on 3 consecutive cycles with 1,2,7.
REQ-037 Push 4 packets, assert RESET_N low after the first strobe -> all outputs 0 immediately; no further strobes after release.
REQ-038 Force 65536 non-local packets -> drop_count saturates at 16'hFFFF.

Source files
------------

// File: rtl/spike_pkg.sv
// spike_pkg: shared packet layout and FSM encodings for the spike receiver
package spike_pkg;
  localparam int SPK_ADDR_W = 12;
  localparam int SPK_FIELDS = 2;
  localparam int SPK_SRC_FIELD = 1;
  localparam int SPK_DST_FIELD = 0;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DISPATCH = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  function automatic int field_lsb(input int field, input int addr_w);
    return field * addr_w;
  endfunction
endpackage

// File: rtl/spike_packet_receiver_if.sv
// spike_packet_receiver_if: packet ingress valid/ready handshake
interface spike_packet_receiver_if import spike_pkg::*; #(parameter int ADDR_W = SPK_ADDR_W);
  logic [SPK_FIELDS*ADDR_W-1:0] pkt_in;
  logic pkt_valid;
  logic pkt_ready;
  modport master(output pkt_in, pkt_valid, input pkt_ready);
  modport slave(input pkt_in, pkt_valid, output pkt_ready);
endinterface

// File: rtl/spike_fifo.sv
// spike_fifo: single-clock ingress FIFO with occupancy count
module spike_fifo #(
  parameter int W = 24,
  parameter int DEPTH = 8
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    push,
  input  logic [W-1:0]            wdata,
  input  logic                    pop,
  output logic [W-1:0]            rdata,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem[rd_ptr];
  // pointers and occupancy; a full FIFO refuses a push even on a pop cycle
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  // storage needs no reset: a slot is only read after it has been written
  always_ff @(posedge CLK)
    if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/spike_packet_receiver.sv
// spike_packet_receiver: buffers spike packets and strobes them onto local MAC lanes
module spike_packet_receiver import spike_pkg::*; #(
  parameter int NUM_NEURONS = 10,
  parameter int ADDR_W = SPK_ADDR_W,
  parameter int BASE_ADDR = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic                          clear,
  spike_packet_receiver_if.slave        pkt,
  output logic [NUM_NEURONS*ADDR_W-1:0] src_addr_out,
  output logic [NUM_NEURONS-1:0]        src_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   drop_count
);
  localparam int PW = SPK_FIELDS * ADDR_W;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SRC_LSB = field_lsb(SPK_SRC_FIELD, ADDR_W);
  localparam int DST_LSB = field_lsb(SPK_DST_FIELD, ADDR_W);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(BASE_ADDR + NUM_NEURONS);
  logic [1:0] state, state_nx;
  logic [PW-1:0] head;
  logic [ADDR_W-1:0] in_dst, head_src, head_off;
  logic accept, local_dst, push, pop, full, empty, last_pop;
  assign in_dst = pkt.pkt_in[DST_LSB +: ADDR_W];
  assign local_dst = in_dst >= BASE && {1'b0, in_dst} < LIMIT;
  assign pkt.pkt_ready = !full;
  assign accept = pkt.pkt_valid && pkt.pkt_ready;
  assign push = accept && local_dst;
  assign pop = state == ST_DISPATCH && !clear && !empty;
  assign last_pop = pop && !push && fifo_count == CW'(1);
  assign head_src = head[SRC_LSB +: ADDR_W];
  assign head_off = head[DST_LSB +: ADDR_W] - BASE;
  spike_fifo #(.W(PW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .push(push),
    .wdata(pkt.pkt_in),
    .pop(pop),
    .rdata(head),
    .count(fifo_count),
    .full(full),
    .empty(empty)
  );
  // clear dominates; dispatch continues until the final buffered entry pops
  always_comb
    state_nx = clear ? ST_HOLD :
               state == ST_DISPATCH ? (last_pop ? ST_IDLE : ST_DISPATCH) :
               (empty ? ST_IDLE : ST_DISPATCH);
  // state register
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) state <= ST_IDLE;
    else state <= state_nx;
  // count non-local packets that were accepted and discarded, saturating
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) drop_count <= '0;
    else if (accept && !local_dst && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
  for (genvar k = 0; k < NUM_NEURONS; k++) begin : g_lane
    logic hit;
    assign hit = pop && head_off == ADDR_W'(k);
    // one-cycle strobe; the address slice keeps its last delivered value
    always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
        src_valid[k] <= 1'b0;
        src_addr_out[k*ADDR_W +: ADDR_W] <= '0;
      end else begin
        src_valid[k] <= hit;
        if (hit) src_addr_out[k*ADDR_W +: ADDR_W] <= head_src;
      end
  end
endmodule
